// File: rtl/sgd_row_server_if.sv
// rtl/sgd_row_server_if.sv - word-stream handshakes between the row server and its host
interface sgd_row_server_if #(
  parameter int LENGTH = 16
);
  logic [LENGTH-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] res_word;
  logic              res_valid;
  logic              res_ready;

  // host side: feeds training words, consumes result words
  modport master (
    output in_word, in_valid, res_ready,
    input  in_ready, res_word, res_valid
  );

  // row server side
  modport slave (
    input  in_word, in_valid, res_ready,
    output in_ready, res_word, res_valid
  );
endinterface

// File: rtl/sgd_row_server.sv
// rtl/sgd_row_server.sv - packs training words into rows, serves them to the engine, returns weights
module sgd_row_server #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int DP           = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] cfg_rows,
  input  logic [ADDR_WIDTH-1:0] sgd_addr,
  inout  wire  [DATA_WIDTH-1:0] sgd_data,
  input  logic                  sgd_done,
  output logic                  sgd_rst,
  output logic                  busy,
  output logic                  err,
  sgd_row_server_if.slave       io
);

  localparam int WCW    = $clog2(MAX_FEATURES + 1);
  localparam int MEM_AW = $clog2(DP + 1);
  localparam int ASM_W  = DATA_WIDTH - LENGTH;

  typedef enum logic [2:0] {IDLE, LOAD, SERVE, CAPTURE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0] rows_q, rows_d;
  // holds the first 15 words of a row; the 16th comes straight from in_word
  logic [ASM_W-1:0]      asm_q, asm_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [WCW-1:0]        res_idx_q, res_idx_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [0:DP];
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  drive_en;
  logic                  cfg_ok;
  logic                  beat;
  logic                  last_word;
  logic                  last_row;
  logic                  res_hs;

  assign cfg_ok    = (cfg_rows >= ADDR_WIDTH'(2)) && (cfg_rows <= ADDR_WIDTH'(DP + 1));
  assign beat      = (state_q == LOAD) && io.in_valid;
  assign last_word = (word_cnt_q == WCW'(MAX_FEATURES));
  assign last_row  = (row_cnt_q == rows_q - ADDR_WIDTH'(1));
  assign res_hs    = (state_q == DRAIN) && io.res_ready;
  assign mem_wdata = {asm_q, io.in_word};

  // state and datapath registers; reset aborts any load or transfer in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      rows_q     <= '0;
      asm_q      <= '0;
      res_q      <= '0;
      res_idx_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rows_q     <= rows_d;
      asm_q      <= asm_d;
      res_q      <= res_d;
      res_idx_q  <= res_idx_d;
      err_q      <= err_d;
    end
  end

  // row memory: no reset, rows past the configured count are never read out
  always_ff @(posedge CLK) begin
    if (mem_we) mem[row_cnt_q[MEM_AW-1:0]] <= mem_wdata;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start && cfg_ok) state_d = LOAD;
      LOAD:    if (beat && last_word && last_row) state_d = SERVE;
      SERVE:   if (sgd_done) state_d = CAPTURE;
      CAPTURE: state_d = DRAIN;
      DRAIN:   if (res_hs && res_idx_q == WCW'(MAX_FEATURES)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // counters, row assembly, weight capture and config error tracking
  always_comb begin
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    rows_d     = rows_q;
    asm_d      = asm_q;
    res_d      = res_q;
    res_idx_d  = res_idx_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (cfg_ok) begin
            rows_d     = cfg_rows;
            word_cnt_d = '0;
            row_cnt_d  = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          asm_d      = {asm_q[ASM_W-LENGTH-1:0], io.in_word};
          word_cnt_d = word_cnt_q + WCW'(1);
          if (last_word) begin
            mem_we    = 1'b1;
            row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      CAPTURE: res_d = sgd_data;
      DRAIN:   if (res_hs) res_idx_d = res_idx_q + WCW'(1);
      default: ;
    endcase
  end

  // outputs; the bus driver drops out the instant sgd_done rises
  always_comb begin
    drive_en     = (state_q == SERVE) && !sgd_done;
    rd_data      = (sgd_addr < rows_q) ? mem[sgd_addr[MEM_AW-1:0]] : '0;
    io.in_ready  = (state_q == LOAD);
    sgd_rst      = (state_q == IDLE) || (state_q == LOAD);
    busy         = (state_q != IDLE);
    err          = err_q;
    io.res_valid = (state_q == DRAIN);
    io.res_word  = '0;
    if (state_q == DRAIN) io.res_word = res_q[DATA_WIDTH-1-LENGTH*int'(res_idx_q) -: LENGTH];
  end

  assign sgd_data = drive_en ? rd_data : {DATA_WIDTH{1'bz}};

endmodule
